// File: rtl/leg_fifo_queue.sv
// Circular FIFO for the LEG CPU: push at the tail, pop from the head, zero-latency read.
// Pointers carry an extra wrap bit so full and empty are distinguishable without a counter.
module leg_fifo_queue #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PUSH,
  input  logic                  POP,
  input  logic                  CLR,
  input  logic [WORD_WIDTH-1:0] VALUE,
  output logic [WORD_WIDTH-1:0] OUTPUT,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic [ADDR_W:0]       COUNT,
  output logic                  OVF,
  output logic                  UNF
);

  localparam logic [ADDR_W:0] PtrOne = {{ADDR_W{1'b0}}, 1'b1};

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic            empty;
  logic            full;
  logic            pop_ok;
  logic            push_ok;
  logic            mem_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  always_comb begin
    rd_addr = rd_ptr_q[ADDR_W-1:0];
    wr_addr = wr_ptr_q[ADDR_W-1:0];
    empty   = (rd_ptr_q == wr_ptr_q);
    full    = (rd_addr == wr_addr) && (rd_ptr_q[ADDR_W] != wr_ptr_q[ADDR_W]);
    pop_ok  = POP & ~empty;
    // A pop in the same cycle frees the head slot, so a full queue can still accept.
    push_ok = PUSH & (~full | pop_ok);
    mem_we  = push_ok & ~CLR;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (CLR) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrOne;
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
      if (PUSH && !push_ok) ovf_d = 1'b1;
      if (POP && !pop_ok)   unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= VALUE;
  end

  always_comb begin
    OUTPUT = pop_ok ? mem[rd_addr] : '0;
    EMPTY  = empty;
    FULL   = full;
    COUNT  = wr_ptr_q - rd_ptr_q;
    OVF    = ovf_q;
    UNF    = unf_q;
  end

endmodule

// File: tb/tb_leg_fifo_queue.sv
// Self-checking bench for leg_fifo_queue: directed and random traffic against a queue-based model.
module tb_leg_fifo_queue;

  localparam int W = 8;
  localparam int D = 32;
  localparam int AW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          PUSH = 1'b0;
  logic          POP = 1'b0;
  logic          CLR = 1'b0;
  logic [W-1:0]  VALUE = '0;
  logic [W-1:0]  OUTPUT;
  logic          EMPTY;
  logic          FULL;
  logic [AW:0]   COUNT;
  logic          OVF;
  logic          UNF;

  leg_fifo_queue #(.WORD_WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .PUSH(PUSH), .POP(POP), .CLR(CLR), .VALUE(VALUE),
    .OUTPUT(OUTPUT), .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT), .OVF(OVF), .UNF(UNF)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] q[$];
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] exp_out);
    chk({tag, ".OUTPUT"}, 32'(OUTPUT), 32'(exp_out));
    chk({tag, ".EMPTY"},  32'(EMPTY),  32'(q.size() == 0));
    chk({tag, ".FULL"},   32'(FULL),   32'(q.size() == D));
    chk({tag, ".COUNT"},  32'(COUNT),  32'(q.size()));
    chk({tag, ".OVF"},    32'(OVF),    32'(m_ovf));
    chk({tag, ".UNF"},    32'(UNF),    32'(m_unf));
  endtask

  // One clock: drive at negedge, check combinational view, then apply the edge to the model.
  task automatic cycle(input string tag, input logic p, input logic po, input logic c,
                       input logic [W-1:0] v);
    logic [W-1:0] exp_out;
    logic pop_acc, push_acc;
    @(negedge clk);
    PUSH = p; POP = po; CLR = c; VALUE = v;
    #1;
    pop_acc  = po && (q.size() > 0);
    push_acc = p && ((q.size() < D) || pop_acc);
    exp_out  = pop_acc ? q[0] : '0;
    chk_all(tag, exp_out);
    @(posedge clk);
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (pop_acc) void'(q.pop_front());
      if (push_acc) q.push_back(v);
      if (p && !push_acc) m_ovf = 1'b1;
      if (po && !pop_acc) m_unf = 1'b1;
    end
  endtask

  initial begin
    // 1. reset and idle
    #3;
    chk_all("reset", '0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) cycle("idle", 1'b0, 1'b0, 1'b0, 8'h00);

    // 2. small push/pop
    cycle("push11", 1'b1, 1'b0, 1'b0, 8'h11);
    cycle("push22", 1'b1, 1'b0, 1'b0, 8'h22);
    cycle("push33", 1'b1, 1'b0, 1'b0, 8'h33);
    repeat (3) cycle("pop3", 1'b0, 1'b1, 1'b0, 8'h00);
    cycle("empty_after", 1'b0, 1'b0, 1'b0, 8'h00);

    // 3. fill, overflow, drain
    for (int i = 0; i < D; i++) cycle("fill", 1'b1, 1'b0, 1'b0, W'(i));
    cycle("ovf_push", 1'b1, 1'b0, 1'b0, 8'hAA);
    for (int i = 0; i < D; i++) cycle("drain", 1'b0, 1'b1, 1'b0, 8'h00);
    cycle("clr_ovf", 1'b0, 1'b0, 1'b1, 8'h00);

    // 4. offset pointers then simultaneous push/pop across the wrap
    for (int i = 0; i < 5; i++) cycle("pre", 1'b1, 1'b0, 1'b0, W'($urandom));
    for (int i = 0; i < 5; i++) cycle("prepop", 1'b0, 1'b1, 1'b0, 8'h00);
    cycle("lead", 1'b1, 1'b0, 1'b0, W'($urandom));
    for (int i = 0; i < 40; i++) cycle("pushpop", 1'b1, 1'b1, 1'b0, W'($urandom));
    cycle("drain1", 1'b0, 1'b1, 1'b0, 8'h00);

    // 5. simultaneous on empty
    cycle("empty_pp", 1'b1, 1'b1, 1'b0, 8'h5A);
    cycle("pop5a", 1'b0, 1'b1, 1'b0, 8'h00);
    cycle("clr_unf", 1'b0, 1'b0, 1'b1, 8'h00);

    // 6. simultaneous on full, then CLR
    for (int i = 0; i < D; i++) cycle("fill2", 1'b1, 1'b0, 1'b0, W'($urandom));
    cycle("full_pp", 1'b1, 1'b1, 1'b0, 8'h77);
    cycle("full_hold", 1'b0, 1'b0, 1'b0, 8'h00);
    cycle("clr_with_ops", 1'b1, 1'b1, 1'b1, 8'h99);
    cycle("after_clr", 1'b0, 1'b0, 1'b0, 8'h00);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      cycle("rand", 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 40) == 0), W'($urandom));
    end

    // mid-burst async reset
    for (int i = 0; i < 6; i++) cycle("burst", 1'b1, 1'b0, 1'b0, W'($urandom));
    cycle("burst_ovf", 1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    PUSH = 1'b1; POP = 1'b0; VALUE = 8'hC3;
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    chk_all("async_rst", '0);
    PUSH = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cycle("post_rst", 1'b0, 1'b1, 1'b0, 8'h00);
    cycle("post_rst2", 1'b1, 1'b0, 1'b0, 8'h3C);
    cycle("post_rst3", 1'b0, 1'b1, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
